// File: rtl/median_line_buffer.sv
// median_line_buffer: buffers the two previous raster lines of a pixel stream
// and emits three vertically aligned words (rows r-2, r-1, r) per accepted
// pixel once two full lines of the current frame have been primed.
module median_line_buffer #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned LINE_WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word0,
   output logic [WIDTH-1:0] out_word1,
   output logic [WIDTH-1:0] out_word2,
   output logic             out_last
);

   localparam int unsigned      COL_W      = $clog2(LINE_WIDTH);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(LINE_WIDTH - 1);
   localparam logic [1:0]       ROW_STREAM = 2'd2;

   // line0 holds the older line, line1 the newer; contents are never reset
   logic [WIDTH-1:0] line0_q [LINE_WIDTH];
   logic [WIDTH-1:0] line1_q [LINE_WIDTH];

   logic [COL_W-1:0] col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [WIDTH-1:0] out_word0_q, out_word0_d;
   logic [WIDTH-1:0] out_word1_q, out_word1_d;
   logic [WIDTH-1:0] out_word2_q, out_word2_d;

   logic             acc;
   logic             stream;
   logic [WIDTH-1:0] rd0, rd1;

   // Single output register without skid: accept only when it is free or draining
   assign in_ready = !out_valid_q || out_ready;
   assign acc      = in_valid && in_ready;
   assign stream   = (row_q == ROW_STREAM);

   // Asynchronous reads observe the pre-write contents of the current column
   assign rd0 = line0_q[col_q];
   assign rd1 = line1_q[col_q];

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_word0 = out_word0_q;
   assign out_word1 = out_word1_q;
   assign out_word2 = out_word2_q;

   // Next-state for the output register and the column/row position
   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_word0_d = out_word0_q;
      out_word1_d = out_word1_q;
      out_word2_d = out_word2_q;
      col_d       = col_q;
      row_d       = row_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (acc) begin
         if (stream) begin
            out_valid_d = 1'b1;
            out_last_d  = in_last;
            out_word0_d = rd0;
            out_word1_d = rd1;
            out_word2_d = in_data;
         end

         // End of frame restarts priming even when it lands mid-line
         if (in_last) begin
            col_d = '0;
            row_d = '0;
         end else if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q != ROW_STREAM) begin
               row_d = row_q + 2'd1;
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_word0_q <= '0;
         out_word1_q <= '0;
         out_word2_q <= '0;
         col_q       <= '0;
         row_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_word0_q <= out_word0_d;
         out_word1_q <= out_word1_d;
         out_word2_q <= out_word2_d;
         col_q       <= col_d;
         row_q       <= row_d;
      end
   end

   // Line rotation: the newer line's word moves to the older line at this column
   always_ff @(posedge clk) begin
      if (acc && !rst) begin
         line0_q[col_q] <= rd1;
         line1_q[col_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_median_line_buffer.sv
// Directed and randomised-stall checks for median_line_buffer (LINE_WIDTH=4).
module tb_median_line_buffer;

   localparam int W  = 16;
   localparam int LW = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_word0, out_word1, out_word2;
   logic         out_last;

   int n_tests = 0;
   int n_fail  = 0;
   logic ready_seen;

   median_line_buffer #(
      .WIDTH      (W),
      .LINE_WIDTH (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word0 (out_word0),
      .out_word1 (out_word1),
      .out_word2 (out_word2),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [49:0] win(input int a, input int b, input int c, input logic l);
      return {1'b1, l, W'(a), W'(b), W'(c)};
   endfunction

   function automatic logic [49:0] obs();
      return {out_valid, out_last, out_word0, out_word1, out_word2};
   endfunction

   // Drive one cycle of inputs, note in_ready before the edge, sample 1 unit after it
   task automatic step(input logic v, input int d, input logic l, input logic r);
      in_valid  = v;
      in_data   = W'(d);
      in_last   = l;
      out_ready = r;
      #1;
      ready_seen = in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hbeef;
      in_last   = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      n_tests++;
      if (obs() !== 50'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", obs(), 50'h0);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_prime_stream();
      do_reset();
      for (int p = 0; p < 12; p++) begin
         step(1'b1, p, 1'b0, 1'b1);
         n_tests++;
         if (p < 8) begin
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL prime_no_valid p=%0d: got %b expected 0", p, out_valid);
            end
         end else if (obs() !== win(p - 8, p - 4, p, 1'b0)) begin
            n_fail++;
            $display("FAIL stream_window p=%0d: got %h expected %h", p, obs(),
                     win(p - 8, p - 4, p, 1'b0));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int p = 0; p < 10; p++) step(1'b1, p, 1'b0, 1'b1);
      n_tests++;
      if (obs() !== win(1, 5, 9, 1'b0)) begin
         n_fail++;
         $display("FAIL bp_before: got %h expected %h", obs(), win(1, 5, 9, 1'b0));
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 10, 1'b0, 1'b0);
         n_tests++;
         if (ready_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready k=%0d: got %b expected 0", k, ready_seen);
         end
         n_tests++;
         if (obs() !== win(1, 5, 9, 1'b0)) begin
            n_fail++;
            $display("FAIL bp_hold k=%0d: got %h expected %h", k, obs(), win(1, 5, 9, 1'b0));
         end
      end
      for (int p = 10; p < 12; p++) begin
         step(1'b1, p, 1'b0, 1'b1);
         n_tests++;
         if (ready_seen !== 1'b1 || obs() !== win(p - 8, p - 4, p, 1'b0)) begin
            n_fail++;
            $display("FAIL bp_release p=%0d: ready %b got %h expected %h", p, ready_seen,
                     obs(), win(p - 8, p - 4, p, 1'b0));
         end
      end
   endtask

   // Continues the frame left by test_backpressure into a fourth row
   task automatic test_row_wrap();
      for (int p = 12; p < 16; p++) begin
         step(1'b1, p, 1'b0, 1'b1);
         n_tests++;
         if (obs() !== win(p - 8, p - 4, p, 1'b0)) begin
            n_fail++;
            $display("FAIL row_wrap p=%0d: got %h expected %h", p, obs(),
                     win(p - 8, p - 4, p, 1'b0));
         end
      end
   endtask

   task automatic test_mid_line_last();
      do_reset();
      for (int p = 0; p < 10; p++) step(1'b1, p, (p == 9), 1'b1);
      n_tests++;
      if (obs() !== win(1, 5, 9, 1'b1)) begin
         n_fail++;
         $display("FAIL last_window: got %h expected %h", obs(), win(1, 5, 9, 1'b1));
      end
      for (int p = 100; p < 108; p++) begin
         step(1'b1, p, 1'b0, 1'b1);
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL last_reprime p=%0d: got %b expected 0", p, out_valid);
         end
      end
      step(1'b1, 108, 1'b0, 1'b1);
      n_tests++;
      if (obs() !== win(100, 104, 108, 1'b0)) begin
         n_fail++;
         $display("FAIL last_next_frame: got %h expected %h", obs(), win(100, 104, 108, 1'b0));
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      for (int p = 0; p < 10; p++) step(1'b1, p, 1'b0, 1'b1);
      // Hold the window valid so only reset can clear it
      step(1'b0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      step(1'b0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_clear: got valid %b last %b expected 0 0", out_valid, out_last);
      end
      for (int p = 200; p < 208; p++) begin
         step(1'b1, p, 1'b0, 1'b1);
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_reprime p=%0d: got %b expected 0", p, out_valid);
         end
      end
      step(1'b1, 208, 1'b0, 1'b1);
      n_tests++;
      if (obs() !== win(200, 204, 208, 1'b0)) begin
         n_fail++;
         $display("FAIL rst_mid_window: got %h expected %h", obs(), win(200, 204, 208, 1'b0));
      end
   endtask

   task automatic test_random_stall();
      logic [49:0] exp_q[$];
      logic [49:0] e;
      int f = 0, i = 0, cycles = 0, fidx = 0;
      int fcnt[3] = '{0, 0, 0};
      bit done = 0;
      do_reset();
      while (!done && cycles < 3000) begin
         cycles++;
         in_valid  = (f < 3) && ($urandom_range(0, 3) != 0);
         in_data   = W'(f * 256 + i + 7);
         in_last   = (i == 23);
         out_ready = (f >= 3) || ($urandom_range(0, 2) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL soak_extra: got %h expected none", obs());
            end else begin
               e = exp_q.pop_front();
               if (obs() !== e) begin
                  n_fail++;
                  $display("FAIL soak_window: got %h expected %h", obs(), e);
               end
            end
            if (fidx < 3) fcnt[fidx]++;
            if (out_last) fidx++;
         end
         if (in_valid && in_ready) begin
            if (i >= 2 * LW) begin
               exp_q.push_back(win(f * 256 + i - 8 + 7, f * 256 + i - 4 + 7, f * 256 + i + 7,
                                   (i == 23)));
            end
            i++;
            if (i == 24) begin
               i = 0;
               f++;
            end
         end
         @(posedge clk);
         #1;
         done = (f == 3) && !out_valid;
      end
      in_valid = 1'b0;
      n_tests++;
      if (!done || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL soak_drain: got done %0d pending %0d expected 1 0", done, exp_q.size());
      end
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (fcnt[k] != 16) begin
            n_fail++;
            $display("FAIL soak_frame_count f=%0d: got %0d expected 16", k, fcnt[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_prime_stream();
      test_backpressure();
      test_row_wrap();
      test_mid_line_last();
      test_reset_mid_frame();
      test_random_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
